mips_ctrl_fsm: RTL
==================

# mips_ctrl_fsm

Multicycle control unit for the MIPS core. It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB, decodes opcode/funct, and drives the 5-bit ALU operation code plus all datapath select and write-enable strobes. It sits upstream of the ALU, register file, PC and memory port, stalls on the memory wait handshake, and halts on an unsupported encoding.

## Interface
- No parameters; all encodings come from `mips_pkg`.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `instr` in 32: current instruction, valid from the cycle after `ir_write`.
- `mem_waitrequest` in 1: memory not ready; holds the current access.
- `mem_read` / `mem_write` out 1 each: memory access strobes.
- `mem_addr_src` out 1: memory address source, 0=PC, 1=ALU result register.
- `ir_write` out 1: load instruction register.
- `alu_control` out 5: ALU op code from `mips_pkg`.
- `alu_src_a` out 2: 0=PC, 1=rs, 2=rt.
- `alu_src_b` out 3: 0=rt, 1=const 4, 2=sign-ext imm, 3=zero-ext imm, 4=shamt, 5=sign-ext imm<<2.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load gated by the ALU `branch` flag.
- `pc_src` out 2: 0=ALU result, 1=branch target register, 2={PC[31:28],instr[25:0],2'b00}, 3=rs.
- `tgt_write` out 1: load branch target register.
- `reg_write` out 1: register file write.
- `reg_dst` out 1: destination register, 0=rt, 1=rd.
- `mem_to_reg` out 1: write-back data, 0=ALU result register, 1=memory data register.
- `active` out 1: high unless halted.

## Operation
- States are RESET, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Every strobe output is 0 in RESET and HALT, and whenever it is not named below.
- **RESET:** one cycle after `reset_n` deasserts, then FETCH.
- **FETCH:**
  - `mem_read=1`, `mem_addr_src=0`, `alu_control=ADD`, `alu_src_a=0`, `alu_src_b=1`.
  - While `mem_waitrequest=1`: stay in FETCH, with `ir_write` and `pc_write` held at 0.
  - Otherwise: `ir_write=1`, `pc_write=1`, `pc_src=0`, go to DECODE.
- **DECODE:** `alu_control=ADD`, `alu_src_a=0`, `alu_src_b=5`, `tgt_write=1`. Next state is EXEC, or HALT if the opcode/funct is unsupported.
- **EXEC, R-type** (opcode 0), funct mapping:
  - 21 ADDU→ADD, 23 SUBU→SUB, 24 AND, 25 OR, 26 XOR: `alu_src_a=1`, `alu_src_b=0`, then WB.
  - 00 SLL, 02 SRL, 03 SRA: `alu_src_a=2`, `alu_src_b=4`, then WB.
  - 19 MULTU→MULT, 1B DIVU→DIV: `alu_src_a=1`, `alu_src_b=0`. The ALU captures HI/LO at this edge. Next is FETCH.
  - 11 MTHI, 13 MTLO: `alu_src_a=1`. Next is FETCH.
  - 10 MFHI, 12 MFLO: then WB.
  - 08 JR: `pc_write=1`, `pc_src=3`, then FETCH.
- **EXEC, I/J-type:**
  - 09 ADDIU→ADD with `alu_src_b=2`; 0C ANDI, 0D ORI, 0E XORI with `alu_src_b=3`. All use `alu_src_a=1`, then WB.
  - 23 LW, 2B SW: ADD, `alu_src_a=1`, `alu_src_b=2`, then MEM.
  - 04 BEQ→EQ, 05 BNE→NE: `alu_src_a=1`, `alu_src_b=0`, `pc_write_cond=1`, `pc_src=1`, then FETCH.
  - 02 J: `pc_write=1`, `pc_src=2`, then FETCH.
- **MEM:**
  - `mem_addr_src=1`; `mem_read=1` for LW, `mem_write=1` for SW.
  - Stays in MEM while `mem_waitrequest=1`.
  - Then LW goes to WB, SW goes to FETCH.
- **WB:** `reg_write=1`. `reg_dst=1` for R-type, 0 otherwise. `mem_to_reg=1` for LW only. Next is FETCH.
- **HALT:** absorbing; `active=0`. Only reset exits.

## Timing
- Reset value: state RESET, all outputs 0, `active=0`. `active` goes to 1 on entering FETCH.
- Assert `reset_n` in any state, including mid-wait: outputs drop to 0 asynchronously and any pending write is abandoned.
- Instruction length with zero wait:
  - 3 cycles: MULTU, DIVU, MTHI, MTLO, branches, J, JR.
  - 4 cycles: ALU ops, shifts, MFHI, MFLO, SW.
  - 5 cycles: LW.
- Each wait cycle adds one cycle. Strobes remain stable throughout a stall.
- Outputs are a Moore function of state plus registered `instr`, except the FETCH/MEM strobes gated by `mem_waitrequest`.
- `mem_read` and `mem_write` are never high together.

## Structure
- Shared `mips_pkg` holds:
  - `alu_op_t` enum: ADD=00000, AND=00001, DIV=00010, EQ=00011, GT=00100, GE=00101, LT=00110, LE=00111, MULT=01000, NE=01001, OR=01010, SLL=01011, SRA=01100, SRL=01101, SUB=01110, XOR=01111, MTHI=10000, MFHI=10001, MTLO=10010, MFLO=10011.
  - Opcode and funct constants.
  - Select-encoding constants.
  - `state_t`.
- One sub-module, `mips_instr_decode`: combinational opcode/funct → {`alu_op_t`, class, legal}. The FSM stays in `mips_ctrl_fsm`.

## Test plan
- Reset, then ADDU with `instr=0x00851021`, zero wait → states RESET, FETCH, DECODE, EXEC, WB. `alu_control=00000`, `alu_src_a=1`, `alu_src_b=0` in EXEC; `reg_write=1`, `reg_dst=1` in WB.
- LW `0x8C880004`, with `mem_waitrequest=1` for 2 cycles in both FETCH and MEM → 9 cycles total. `mem_read` stays high while stalled, and `ir_write`/`pc_write` pulse exactly once. WB shows `mem_to_reg=1`, `reg_dst=0`.
- BNE `0x14A60003` → DECODE has `tgt_write=1`, `alu_src_b=5`. EXEC has `alu_control=01001`, `pc_write_cond=1`, `pc_src=1`. Back in FETCH after 3 cycles.
- MULTU `0x00850019` then MFLO `0x00001012` → MULTU EXEC drives 01000 and returns to FETCH. MFLO EXEC drives 10011 and is followed by WB with `reg_dst=1`.
- Unsupported opcode `0xFC000000` → HALT after DECODE, `active=0`, strobes 0 for 20 cycles. Asserting `reset_n=0` returns to RESET immediately.
- Assert reset during a SW stalled in MEM → `mem_write` drops to 0 asynchronously, and the next FETCH follows release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: ALU ops, opcodes,
// funct codes, datapath select values, FSM states and the control bundle.
package mips_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000,
        ALU_AND  = 5'b00001,
        ALU_DIV  = 5'b00010,
        ALU_EQ   = 5'b00011,
        ALU_GT   = 5'b00100,
        ALU_GE   = 5'b00101,
        ALU_LT   = 5'b00110,
        ALU_LE   = 5'b00111,
        ALU_MULT = 5'b01000,
        ALU_NE   = 5'b01001,
        ALU_OR   = 5'b01010,
        ALU_SLL  = 5'b01011,
        ALU_SRA  = 5'b01100,
        ALU_SRL  = 5'b01101,
        ALU_SUB  = 5'b01110,
        ALU_XOR  = 5'b01111,
        ALU_MTHI = 5'b10000,
        ALU_MFHI = 5'b10001,
        ALU_MTLO = 5'b10010,
        ALU_MFLO = 5'b10011
    } alu_op_t;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;

    // Datapath select encodings
    localparam logic       ADDR_SRC_PC  = 1'b0;
    localparam logic       ADDR_SRC_ALU = 1'b1;
    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_RS     = 2'd1;
    localparam logic [1:0] SRC_A_RT     = 2'd2;
    localparam logic [2:0] SRC_B_RT     = 3'd0;
    localparam logic [2:0] SRC_B_FOUR   = 3'd1;
    localparam logic [2:0] SRC_B_SIMM   = 3'd2;
    localparam logic [2:0] SRC_B_ZIMM   = 3'd3;
    localparam logic [2:0] SRC_B_SHAMT  = 3'd4;
    localparam logic [2:0] SRC_B_BOFF   = 3'd5;
    localparam logic [1:0] PC_SRC_ALU   = 2'd0;
    localparam logic [1:0] PC_SRC_TGT   = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP  = 2'd2;
    localparam logic [1:0] PC_SRC_RS    = 2'd3;

    // How EXEC/MEM/WB treat an instruction
    typedef enum logic [3:0] {
        CLS_RALU,
        CLS_SHIFT,
        CLS_MULDIV,
        CLS_MTHILO,
        CLS_MFHILO,
        CLS_JR,
        CLS_IMM_S,
        CLS_IMM_Z,
        CLS_LW,
        CLS_SW,
        CLS_BRANCH,
        CLS_J
    } instr_class_t;

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    // Registered control bundle; fetch_phase marks FETCH so the
    // wait-gated ir_write/pc_write strobes can be formed at the output.
    typedef struct packed {
        logic       active;
        logic       fetch_phase;
        logic       mem_read;
        logic       mem_write;
        logic       mem_addr_src;
        logic       pc_write;
        logic       pc_write_cond;
        logic       tgt_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] pc_src;
        logic [1:0] alu_src_a;
        logic [2:0] alu_src_b;
        alu_op_t    alu_control;
    } ctrl_t;

endpackage

// File: rtl/mips_instr_decode.sv
// Opcode/funct decoder: ALU op, execution class and legality of an instruction.
// Latency: purely combinational.
// Backpressure: none; evaluated whenever the FSM looks at the instruction.
module mips_instr_decode
    import mips_pkg::*;
(
    input  logic [5:0]   opcode_i,
    input  logic [5:0]   funct_i,
    output alu_op_t      alu_op_o,
    output instr_class_t iclass_o,
    output logic         legal_o
);

    // Map each supported encoding to its op and class; anything else is illegal.
    always_comb begin
        alu_op_o = ALU_ADD;
        iclass_o = CLS_RALU;
        legal_o  = 1'b1;
        if (opcode_i == OP_RTYPE) begin
            case (funct_i)
                FN_ADDU:  begin alu_op_o = ALU_ADD;  iclass_o = CLS_RALU;   end
                FN_SUBU:  begin alu_op_o = ALU_SUB;  iclass_o = CLS_RALU;   end
                FN_AND:   begin alu_op_o = ALU_AND;  iclass_o = CLS_RALU;   end
                FN_OR:    begin alu_op_o = ALU_OR;   iclass_o = CLS_RALU;   end
                FN_XOR:   begin alu_op_o = ALU_XOR;  iclass_o = CLS_RALU;   end
                FN_SLL:   begin alu_op_o = ALU_SLL;  iclass_o = CLS_SHIFT;  end
                FN_SRL:   begin alu_op_o = ALU_SRL;  iclass_o = CLS_SHIFT;  end
                FN_SRA:   begin alu_op_o = ALU_SRA;  iclass_o = CLS_SHIFT;  end
                FN_MULTU: begin alu_op_o = ALU_MULT; iclass_o = CLS_MULDIV; end
                FN_DIVU:  begin alu_op_o = ALU_DIV;  iclass_o = CLS_MULDIV; end
                FN_MTHI:  begin alu_op_o = ALU_MTHI; iclass_o = CLS_MTHILO; end
                FN_MTLO:  begin alu_op_o = ALU_MTLO; iclass_o = CLS_MTHILO; end
                FN_MFHI:  begin alu_op_o = ALU_MFHI; iclass_o = CLS_MFHILO; end
                FN_MFLO:  begin alu_op_o = ALU_MFLO; iclass_o = CLS_MFHILO; end
                FN_JR:    begin alu_op_o = ALU_ADD;  iclass_o = CLS_JR;     end
                default:  legal_o = 1'b0;
            endcase
        end else begin
            case (opcode_i)
                OP_ADDIU: begin alu_op_o = ALU_ADD; iclass_o = CLS_IMM_S;  end
                OP_ANDI:  begin alu_op_o = ALU_AND; iclass_o = CLS_IMM_Z;  end
                OP_ORI:   begin alu_op_o = ALU_OR;  iclass_o = CLS_IMM_Z;  end
                OP_XORI:  begin alu_op_o = ALU_XOR; iclass_o = CLS_IMM_Z;  end
                OP_LW:    begin alu_op_o = ALU_ADD; iclass_o = CLS_LW;     end
                OP_SW:    begin alu_op_o = ALU_ADD; iclass_o = CLS_SW;     end
                OP_BEQ:   begin alu_op_o = ALU_EQ;  iclass_o = CLS_BRANCH; end
                OP_BNE:   begin alu_op_o = ALU_NE;  iclass_o = CLS_BRANCH; end
                OP_J:     begin alu_op_o = ALU_ADD; iclass_o = CLS_J;      end
                default:  legal_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multicycle MIPS control: FETCH/DECODE/EXEC/MEM/WB sequencing and strobes.
// Latency: 3-5 cycles per instruction plus one per memory wait cycle.
// Backpressure: mem_waitrequest holds FETCH or MEM with strobes stable.
module mips_ctrl_fsm
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic        mem_waitrequest,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_addr_src,
    output logic        ir_write,
    output logic [4:0]  alu_control,
    output logic [1:0]  alu_src_a,
    output logic [2:0]  alu_src_b,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  pc_src,
    output logic        tgt_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        active
);

    state_t       state_q, state_d;
    ctrl_t        ctrl_q, ctrl_d;
    alu_op_t      dec_op;
    instr_class_t dec_cls;
    logic         dec_legal;
    logic         unused_instr_bits;

    assign unused_instr_bits = ^instr[25:6];

    mips_instr_decode u_decode (
        .opcode_i (instr[31:26]),
        .funct_i  (instr[5:0]),
        .alu_op_o (dec_op),
        .iclass_o (dec_cls),
        .legal_o  (dec_legal)
    );

    // Next-state sequencing; instr is only consulted from DECODE onwards.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  if (!mem_waitrequest) state_d = S_DECODE;
            S_DECODE: state_d = dec_legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                case (dec_cls)
                    CLS_RALU, CLS_SHIFT, CLS_MFHILO,
                    CLS_IMM_S, CLS_IMM_Z:          state_d = S_WB;
                    CLS_LW, CLS_SW:                state_d = S_MEM;
                    default:                       state_d = S_FETCH;
                endcase
            end
            S_MEM:    if (!mem_waitrequest) state_d = (dec_cls == CLS_LW) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // Control values for the state being entered, so they are registered with it.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH: begin
                ctrl_d.active      = 1'b1;
                ctrl_d.fetch_phase = 1'b1;
                ctrl_d.mem_read    = 1'b1;
                ctrl_d.mem_addr_src = ADDR_SRC_PC;
                ctrl_d.alu_control = ALU_ADD;
                ctrl_d.alu_src_a   = SRC_A_PC;
                ctrl_d.alu_src_b   = SRC_B_FOUR;
                ctrl_d.pc_src      = PC_SRC_ALU;
            end
            S_DECODE: begin
                ctrl_d.active      = 1'b1;
                ctrl_d.tgt_write   = 1'b1;
                ctrl_d.alu_control = ALU_ADD;
                ctrl_d.alu_src_a   = SRC_A_PC;
                ctrl_d.alu_src_b   = SRC_B_BOFF;
            end
            S_EXEC: begin
                ctrl_d.active      = 1'b1;
                ctrl_d.alu_control = dec_op;
                case (dec_cls)
                    CLS_RALU, CLS_MULDIV: begin
                        ctrl_d.alu_src_a = SRC_A_RS;
                        ctrl_d.alu_src_b = SRC_B_RT;
                    end
                    CLS_SHIFT: begin
                        ctrl_d.alu_src_a = SRC_A_RT;
                        ctrl_d.alu_src_b = SRC_B_SHAMT;
                    end
                    CLS_MTHILO: ctrl_d.alu_src_a = SRC_A_RS;
                    CLS_JR: begin
                        ctrl_d.pc_write = 1'b1;
                        ctrl_d.pc_src   = PC_SRC_RS;
                    end
                    CLS_IMM_S, CLS_LW, CLS_SW: begin
                        ctrl_d.alu_src_a = SRC_A_RS;
                        ctrl_d.alu_src_b = SRC_B_SIMM;
                    end
                    CLS_IMM_Z: begin
                        ctrl_d.alu_src_a = SRC_A_RS;
                        ctrl_d.alu_src_b = SRC_B_ZIMM;
                    end
                    CLS_BRANCH: begin
                        ctrl_d.alu_src_a     = SRC_A_RS;
                        ctrl_d.alu_src_b     = SRC_B_RT;
                        ctrl_d.pc_write_cond = 1'b1;
                        ctrl_d.pc_src        = PC_SRC_TGT;
                    end
                    CLS_J: begin
                        ctrl_d.pc_write = 1'b1;
                        ctrl_d.pc_src   = PC_SRC_JUMP;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ctrl_d.active       = 1'b1;
                ctrl_d.mem_addr_src = ADDR_SRC_ALU;
                ctrl_d.mem_read     = (dec_cls == CLS_LW);
                ctrl_d.mem_write    = (dec_cls == CLS_SW);
            end
            S_WB: begin
                ctrl_d.active     = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.reg_dst    = (instr[31:26] == OP_RTYPE);
                ctrl_d.mem_to_reg = (dec_cls == CLS_LW);
            end
            default: ;
        endcase
    end

    // State and control registers; reset clears every strobe immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RESET;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // The IR/PC update in FETCH only happens on the cycle memory delivers.
    assign ir_write      = ctrl_q.fetch_phase & ~mem_waitrequest;
    assign pc_write      = ctrl_q.pc_write | ir_write;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign mem_addr_src  = ctrl_q.mem_addr_src;
    assign alu_control   = ctrl_q.alu_control;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign pc_src        = ctrl_q.pc_src;
    assign tgt_write     = ctrl_q.tgt_write;
    assign reg_write     = ctrl_q.reg_write;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign active        = ctrl_q.active;

endmodule
